// File: rtl/i2s_capture_writer.sv
// Record path: deserialises codec I2S data into 16-bit words, buffers them in a small FIFO
// and streams them to SDRAM through the Avalon bridge as interleaved L,R words.
module i2s_capture_writer #(
  parameter int          BIT_DEPTH  = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] ADDR_RESET = 25'h4f
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 I2S_DOUT,
  input  logic                 I2S_LRCLK,
  input  logic                 I2S_SCLK,
  output logic [24:0]          ADDR_WR,
  output logic [BIT_DEPTH-1:0] WRdata,
  output logic                 WRen,
  input  logic                 avalon_bridge_acknowledge,
  input  logic                 REC_enable,
  input  logic                 ADDR_load,
  input  logic [24:0]          ADDR_start,
  input  logic [24:0]          ADDR_end,
  input  logic                 loop_en,
  output logic                 rec_done,
  output logic                 overflow
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_M1  = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [5:0]     LAST_BIT = 6'(BIT_DEPTH);

  typedef enum logic {W_IDLE, W_REQ} wstate_t;

  wstate_t state, state_next;

  logic [1:0] dout_sync, sclk_sync, lrclk_sync;
  logic       sclk_prev, lrclk_prev;
  logic       dout_bit, sclk_rise, lr_edge, lr_fall, slot_right;

  logic                 aligned, left_ok;
  logic [5:0]           bit_cnt;
  logic [BIT_DEPTH-1:0] shift_reg, word;
  logic                 capture_on, word_done, left_fits;
  logic                 push_left, push_right, drop_left, push, pop, load_take;

  logic [BIT_DEPTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_count;
  logic                 fifo_empty;

  logic [24:0]          wr_addr;
  logic [BIT_DEPTH-1:0] wr_data;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      dout_sync  <= '0;
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sclk_prev  <= 1'b0;
      lrclk_prev <= 1'b0;
    end else begin
      dout_sync  <= {dout_sync[0], I2S_DOUT};
      sclk_sync  <= {sclk_sync[0], I2S_SCLK};
      lrclk_sync <= {lrclk_sync[0], I2S_LRCLK};
      sclk_prev  <= sclk_sync[1];
      lrclk_prev <= lrclk_sync[1];
    end
  end

  assign dout_bit   = dout_sync[1];
  assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
  assign lr_edge    = lrclk_sync[1] ^ lrclk_prev;
  assign lr_fall    = lrclk_prev & ~lrclk_sync[1];
  assign slot_right = lrclk_sync[1];

  // A load is only honoured between requests so a pending write finishes at its old address.
  assign load_take  = ADDR_load & ~WRen;
  assign pop        = (state == W_REQ) & avalon_bridge_acknowledge;
  assign fifo_empty = (fifo_count == '0);

  assign capture_on = aligned & REC_enable & ~rec_done & ~load_take;
  assign word_done  = capture_on & sclk_rise & ~lr_edge & (bit_cnt == LAST_BIT);
  assign word       = {shift_reg[BIT_DEPTH-2:0], dout_bit};

  // A left word needs room for itself and its right partner, so pairs are never split.
  assign left_fits  = (fifo_count < FULL_M1) | (pop & (fifo_count < FULL_CNT));
  assign push_left  = word_done & ~slot_right & left_fits;
  assign drop_left  = word_done & ~slot_right & ~left_fits;
  assign push_right = word_done & slot_right & left_ok;
  assign push       = push_left | push_right;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      aligned   <= 1'b0;
      left_ok   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (lr_edge) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (sclk_rise) begin
        if (bit_cnt != 6'd63)
          bit_cnt <= bit_cnt + 6'd1;
        if (bit_cnt != 6'd0 && bit_cnt <= LAST_BIT)
          shift_reg <= word;
      end
      if (load_take || !REC_enable) begin
        aligned <= 1'b0;
        left_ok <= 1'b0;
      end else begin
        if (lr_fall)
          aligned <= 1'b1;
        if (lr_fall || push_right)
          left_ok <= 1'b0;
        else if (push_left)
          left_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (load_take)
      overflow <= 1'b0;
    else if (drop_left)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk50) begin
    if (push)
      fifo_mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (load_take) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      state <= W_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      W_IDLE: if (!fifo_empty && !rec_done && !load_take) state_next = W_REQ;
      W_REQ:  if (avalon_bridge_acknowledge) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  always_comb begin
    WRen = (state == W_REQ);
  end

  // Data is latched on entry to W_REQ so it stays put while the bridge stalls.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_addr  <= ADDR_RESET;
      wr_data  <= '0;
      rec_done <= 1'b0;
    end else begin
      if (state == W_IDLE && state_next == W_REQ)
        wr_data <= fifo_mem[rd_ptr];
      if (load_take) begin
        wr_addr  <= ADDR_start;
        rec_done <= 1'b0;
      end else if (pop) begin
        if (wr_addr == ADDR_end) begin
          if (loop_en)
            wr_addr <= ADDR_start;
          else
            rec_done <= 1'b1;
        end else begin
          wr_addr <= wr_addr + 25'd1;
        end
      end
    end
  end

  assign ADDR_WR = wr_addr;
  assign WRdata  = wr_data;

endmodule

// File: tb/tb_i2s_capture_writer.sv
// Directed bench for i2s_capture_writer: drives I2S frames, models the Avalon bridge
// and checks the logged writes against hand-computed addresses and data.
module tb_i2s_capture_writer;

  logic        clk50;
  logic        reset;
  logic        i2s_dout, i2s_lrclk, i2s_sclk;
  logic [24:0] addr_wr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        bridge_ack;
  logic        rec_enable, addr_load, loop_en;
  logic [24:0] addr_start, addr_end;
  logic        rec_done, overflow;

  int checks = 0;
  int errors = 0;

  logic [24:0] q_addr [$];
  logic [15:0] q_data [$];
  logic        in_req, stable_ok, ack_hold;
  logic [24:0] held_addr;
  logic [15:0] held_data;
  int          wait_cnt;

  i2s_capture_writer dut (
    .clk50                     (clk50),
    .reset                     (reset),
    .I2S_DOUT                  (i2s_dout),
    .I2S_LRCLK                 (i2s_lrclk),
    .I2S_SCLK                  (i2s_sclk),
    .ADDR_WR                   (addr_wr),
    .WRdata                    (wr_data),
    .WRen                      (wr_en),
    .avalon_bridge_acknowledge (bridge_ack),
    .REC_enable                (rec_enable),
    .ADDR_load                 (addr_load),
    .ADDR_start                (addr_start),
    .ADDR_end                  (addr_end),
    .loop_en                   (loop_en),
    .rec_done                  (rec_done),
    .overflow                  (overflow)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One stereo frame, I2S timing: LRCLK and data change on SCLK fall, one delay bit per slot.
  task automatic applyStimulus(input logic [15:0] left_word, input logic [15:0] right_word, input int en_at);
    logic [15:0] w;
    for (int k = 0; k < 64; k++) begin
      if (k == 0)  w = left_word;
      if (k == 32) w = right_word;
      i2s_sclk  = 1'b0;
      i2s_lrclk = (k >= 32);
      if ((k % 32) >= 1 && (k % 32) <= 16) begin
        i2s_dout = w[15];
        w = w << 1;
      end else begin
        i2s_dout = 1'b0;
      end
      if (k == en_at) rec_enable = 1'b1;
      #80;
      i2s_sclk = 1'b1;
      #80;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic waitWrites(input int n, input int budget, input string tag);
    int c = 0;
    while (q_addr.size() < n && c < budget) begin
      @(negedge clk50);
      c++;
    end
    checkOutput(tag, 32'(q_addr.size()), 32'(n));
  endtask

  task automatic loadBuffer(input logic [24:0] start_a, input logic [24:0] end_a, input logic lp);
    @(negedge clk50);
    addr_start = start_a;
    addr_end   = end_a;
    loop_en    = lp;
    addr_load  = 1'b1;
    @(negedge clk50);
    addr_load  = 1'b0;
    @(negedge clk50);
  endtask

  // Bridge model: acks three cycles after WRen rises unless held, logs each request once.
  always @(negedge clk50) begin
    if (reset) begin
      bridge_ack = 1'b0;
      in_req     = 1'b0;
    end else if (bridge_ack) begin
      bridge_ack = 1'b0;
      in_req     = 1'b0;
      checkOutput("write_stable", 32'(stable_ok), 32'd1);
      checkOutput("idle_after_ack", 32'(wr_en), 32'd0);
    end else if (wr_en) begin
      if (!in_req) begin
        in_req    = 1'b1;
        stable_ok = 1'b1;
        wait_cnt  = 0;
        held_addr = addr_wr;
        held_data = wr_data;
        q_addr.push_back(addr_wr);
        q_data.push_back(wr_data);
      end else if (addr_wr !== held_addr || wr_data !== held_data) begin
        stable_ok = 1'b0;
      end
      wait_cnt++;
      if (!ack_hold && wait_cnt >= 3) bridge_ack = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bridge_ack = 1'b0;
    in_req     = 1'b0;
    stable_ok  = 1'b1;
    ack_hold   = 1'b0;
    rec_enable = 1'b0;
    addr_load  = 1'b0;
    addr_start = '0;
    addr_end   = '0;
    loop_en    = 1'b0;
    i2s_sclk   = 1'b1;
    i2s_lrclk  = 1'b1;
    i2s_dout   = 1'b0;
    waitCycles(3);
    checkOutput("rst_wren", 32'(wr_en), 32'd0);
    checkOutput("rst_addr", 32'(addr_wr), 32'h4f);
    checkOutput("rst_data", 32'(wr_data), 32'd0);
    checkOutput("rst_done", 32'(rec_done), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    waitCycles(3);

    $display("[TB] basic stereo frame");
    rec_enable = 1'b1;
    loadBuffer(25'h100, 25'h1ff, 1'b0);
    applyStimulus(16'h8001, 16'h7ffe, -1);
    waitWrites(2, 300, "t1_count");
    checkOutput("t1_addr0", 32'(q_addr[0]), 32'h100);
    checkOutput("t1_data0", 32'(q_data[0]), 32'h8001);
    checkOutput("t1_addr1", 32'(q_addr[1]), 32'h101);
    checkOutput("t1_data1", 32'(q_data[1]), 32'h7ffe);

    $display("[TB] enable mid right slot");
    q_addr.delete(); q_data.delete();
    rec_enable = 1'b0;
    waitCycles(2);
    applyStimulus(16'h1111, 16'h2222, 40);
    applyStimulus(16'h3333, 16'h4444, -1);
    waitWrites(2, 300, "t2_count");
    waitCycles(50);
    checkOutput("t2_no_extra", 32'(q_addr.size()), 32'd2);
    checkOutput("t2_addr0", 32'(q_addr[0]), 32'h102);
    checkOutput("t2_data0", 32'(q_data[0]), 32'h3333);
    checkOutput("t2_addr1", 32'(q_addr[1]), 32'h103);
    checkOutput("t2_data1", 32'(q_data[1]), 32'h4444);

    $display("[TB] overflow with stalled bridge");
    q_addr.delete(); q_data.delete();
    loadBuffer(25'h300, 25'h3ff, 1'b0);
    ack_hold = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(16'(16'ha000 + i), 16'(16'hb000 + i), -1);
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    checkOutput("t3_pending", 32'(q_addr.size()), 32'd1);
    checkOutput("t3_wren_held", 32'(wr_en), 32'd1);
    ack_hold = 1'b0;
    waitWrites(4, 300, "t3_count");
    waitCycles(20);
    checkOutput("t3_exact4", 32'(q_addr.size()), 32'd4);
    checkOutput("t3_data0", 32'(q_data[0]), 32'ha000);
    checkOutput("t3_data1", 32'(q_data[1]), 32'hb000);
    checkOutput("t3_data2", 32'(q_data[2]), 32'ha001);
    checkOutput("t3_data3", 32'(q_data[3]), 32'hb001);
    checkOutput("t3_addr3", 32'(q_addr[3]), 32'h303);
    applyStimulus(16'hc000, 16'hd000, -1);
    waitWrites(6, 300, "t3_count_after");
    checkOutput("t3_addr4", 32'(q_addr[4]), 32'h304);
    checkOutput("t3_data4", 32'(q_data[4]), 32'hc000);
    checkOutput("t3_data5", 32'(q_data[5]), 32'hd000);

    $display("[TB] bounded buffer without loop");
    q_addr.delete(); q_data.delete();
    loadBuffer(25'h200, 25'h203, 1'b0);
    checkOutput("t4_ovf_cleared", 32'(overflow), 32'd0);
    applyStimulus(16'h0001, 16'h0002, -1);
    applyStimulus(16'h0003, 16'h0004, -1);
    applyStimulus(16'h0005, 16'h0006, -1);
    waitWrites(4, 300, "t4_count");
    waitCycles(50);
    checkOutput("t4_exact4", 32'(q_addr.size()), 32'd4);
    checkOutput("t4_addr0", 32'(q_addr[0]), 32'h200);
    checkOutput("t4_data0", 32'(q_data[0]), 32'h0001);
    checkOutput("t4_addr3", 32'(q_addr[3]), 32'h203);
    checkOutput("t4_data3", 32'(q_data[3]), 32'h0004);
    checkOutput("t4_done", 32'(rec_done), 32'd1);
    checkOutput("t4_wren_off", 32'(wr_en), 32'd0);

    $display("[TB] bounded buffer with loop");
    q_addr.delete(); q_data.delete();
    loadBuffer(25'h200, 25'h203, 1'b1);
    checkOutput("t4l_done_cleared", 32'(rec_done), 32'd0);
    applyStimulus(16'h0011, 16'h0012, -1);
    applyStimulus(16'h0013, 16'h0014, -1);
    applyStimulus(16'h0015, 16'h0016, -1);
    waitWrites(6, 300, "t4l_count");
    checkOutput("t4l_addr4", 32'(q_addr[4]), 32'h200);
    checkOutput("t4l_data4", 32'(q_data[4]), 32'h0015);
    checkOutput("t4l_addr5", 32'(q_addr[5]), 32'h201);
    checkOutput("t4l_done", 32'(rec_done), 32'd0);

    $display("[TB] reset during pending request");
    q_addr.delete(); q_data.delete();
    ack_hold = 1'b1;
    applyStimulus(16'h0101, 16'h0202, -1);
    applyStimulus(16'h0303, 16'h0404, -1);
    applyStimulus(16'h0505, 16'h0606, -1);
    checkOutput("t5_pre_ovf", 32'(overflow), 32'd1);
    checkOutput("t5_pre_wren", 32'(wr_en), 32'd1);
    @(negedge clk50);
    #3 reset = 1'b1;
    #1;
    checkOutput("t5_wren", 32'(wr_en), 32'd0);
    checkOutput("t5_addr", 32'(addr_wr), 32'h4f);
    checkOutput("t5_ovf", 32'(overflow), 32'd0);
    checkOutput("t5_data", 32'(wr_data), 32'd0);
    @(negedge clk50);
    @(negedge clk50);
    q_addr.delete(); q_data.delete();
    ack_hold = 1'b0;
    reset = 1'b0;
    waitCycles(3);
    applyStimulus(16'h5a5a, 16'ha5a5, -1);
    waitWrites(2, 300, "t5_count");
    checkOutput("t5_addr0", 32'(q_addr[0]), 32'h4f);
    checkOutput("t5_data0", 32'(q_data[0]), 32'h5a5a);
    checkOutput("t5_addr1", 32'(q_addr[1]), 32'h50);
    checkOutput("t5_data1", 32'(q_data[1]), 32'ha5a5);

    $display("[TB] load during pending request");
    q_addr.delete(); q_data.delete();
    ack_hold   = 1'b1;
    addr_start = 25'h400;
    addr_end   = 25'h4ff;
    loop_en    = 1'b0;
    applyStimulus(16'h1234, 16'h5678, -1);
    addr_load = 1'b1;
    waitCycles(5);
    checkOutput("t6_deferred", 32'(wr_en), 32'd1);
    checkOutput("t6_old_addr", 32'(addr_wr), 32'h51);
    ack_hold = 1'b0;
    waitCycles(10);
    addr_load = 1'b0;
    waitCycles(5);
    checkOutput("t6_one_write", 32'(q_addr.size()), 32'd1);
    checkOutput("t6_addr0", 32'(q_addr[0]), 32'h51);
    checkOutput("t6_data0", 32'(q_data[0]), 32'h1234);
    checkOutput("t6_flushed", 32'(wr_en), 32'd0);
    checkOutput("t6_new_addr", 32'(addr_wr), 32'h400);
    applyStimulus(16'h0f0f, 16'hf0f0, -1);
    waitWrites(3, 300, "t6_count");
    checkOutput("t6_addr1", 32'(q_addr[1]), 32'h400);
    checkOutput("t6_data1", 32'(q_data[1]), 32'h0f0f);
    checkOutput("t6_addr2", 32'(q_addr[2]), 32'h401);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
